// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2
//
// Multi-cycle integer divider serving DIV / DIVU in the EXE stage. It uses a
// radix-2 restoring algorithm and produces one quotient bit per cycle. While a
// divide is in flight, stall_o holds the F/D/E stages through the hazard unit.
// When the result is ready it is presented on result_o as {HI, LO}, where
// HI is the remainder and LO is the quotient, with a one-cycle ready_o pulse.
//
// Signed operation divides the operand magnitudes and then applies the sign
// fixups to the result:
//   - the quotient is negative when the operand signs differ;
//   - the remainder takes the sign of the dividend.
// The case -2^(WIDTH-1) / -1 wraps to quotient -2^(WIDTH-1) with remainder 0.
// Divide by zero skips the iterations and returns quotient = all ones and
// remainder = dividend.
//
// Ports
//   clk       core clock; all state changes on the rising edge
//   rst       asynchronous, active-high reset
//   start_i   divide instruction valid in E; held high while E is stalled
//   signed_i  1 = DIV (signed), 0 = DIVU
//   annul_i   flush/exception kill of the E-stage instruction
//   a_i       dividend (rs)
//   b_i       divisor (rt)
//   stall_o   to the hazard unit (stall_divE); combinational
//   ready_o   one-cycle pulse: result_o is valid this cycle
//   result_o  {remainder, quotient}; holds its value until the next ready_o
//
// Timing: if start is seen in IDLE at cycle T, the unit is BUSY during
// T+1 .. T+WIDTH and DONE/ready_o occurs at T+WIDTH+1. For a divide by zero,
// DONE occurs at T+1.
// -----------------------------------------------------------------------------
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 stall_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType         state;
  logic [CntW-1:0]  counter;
  logic [WIDTH-1:0] remReg;      // partial remainder
  logic [WIDTH-1:0] quoReg;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] divisorReg;  // divisor magnitude
  logic             negQuo;      // negate the quotient on completion
  logic             negRem;      // negate the remainder on completion

  // Operand magnitudes at accept time. For DIVU the operands are used as is.
  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as an unsigned value, which
  // is exactly what the wrap-around overflow case needs.
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  assign absA = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign absB = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // The hazard unit must release E in the DONE cycle so that the result
  // advances. A killed instruction never stalls.
  assign stall_o = start_i & ~annul_i & (state != DONE);

  // One restoring step. The shifted remainder needs WIDTH+1 bits because the
  // divisor may use the full WIDTH bits. The top bit of the difference is the
  // borrow: if shiftRem < divisor, the difference wraps into [2^WIDTH, 2^(WIDTH+1)).
  logic [WIDTH:0]   shiftRem;
  logic [WIDTH:0]   trialDiff;
  logic             noBorrow;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] fixedRem;
  logic [WIDTH-1:0] fixedQuo;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred here.
  always_comb begin
    shiftRem  = {remReg, quoReg[WIDTH-1]};
    trialDiff = shiftRem - {1'b0, divisorReg};
    noBorrow  = ~trialDiff[WIDTH];
    nextRem   = noBorrow ? trialDiff[WIDTH-1:0] : shiftRem[WIDTH-1:0];
    nextQuo   = {quoReg[WIDTH-2:0], noBorrow};
    fixedQuo  = negQuo ? -nextQuo : nextQuo;
    fixedRem  = negRem ? -nextRem : nextRem;
  end

  // The final step's values are sign-fixed and registered on the BUSY->DONE
  // edge. As a result, result_o and ready_o are valid in the DONE cycle.
  // NOTE: all state here is assigned with non-blocking assignments. This makes
  // every register see the values from before the edge, regardless of
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well as the control state.
      // This prevents an unknown value from ever reaching result_o, even on
      // a path that looks unreachable.
      state      <= IDLE;
      counter    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      ready_o    <= 1'b0;
      result_o   <= '0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        // A kill drops the operation silently: no pulse, result_o untouched.
        state   <= IDLE;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (b_i == '0) begin
                state    <= DONE;
                ready_o  <= 1'b1;
                result_o <= {a_i, {WIDTH{1'b1}}};
              end else begin
                state      <= BUSY;
                counter    <= '0;
                remReg     <= '0;
                quoReg     <= absA;
                divisorReg <= absB;
                negQuo     <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                negRem     <= signed_i & a_i[WIDTH-1];
              end
            end
          end

          BUSY: begin
            // While BUSY, start_i and the operands are ignored; only the
            // latched copies are used.
            remReg  <= nextRem;
            quoReg  <= nextQuo;
            counter <= counter + 1'b1;
            if (counter == LastCnt) begin
              state    <= DONE;
              counter  <= '0;
              ready_o  <= 1'b1;
              result_o <= {fixedRem, fixedQuo};
            end
          end

          DONE: begin
            // Always pass through IDLE. A back-to-back divide is accepted
            // there on the following cycle.
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_div_radix2
//
// Directed vectors for div_radix2, with two kinds of checking:
//
//   1. A monitor process compares stall_o, ready_o and result_o against a
//      timeline model on every falling edge. The model is based on when each
//      operation started, its fixed latency and its arithmetic result.
//   2. Each vector also checks result_o against a hand-computed literal.
//
// The arithmetic model uses plain SystemVerilog division and modulo.
// -----------------------------------------------------------------------------
module tb_div_radix2;

  localparam int W = 32;
  localparam int LAT = W + 1;  // start cycle to ready_o cycle

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          signed_i;
  logic          annul_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          stall_o;
  logic          ready_o;
  logic [2*W-1:0] result_o;

  div_radix2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counters
  int nChecks = 0;
  int nErr    = 0;

  // Model state, written by the driver
  logic          active    = 1'b0;
  int            startCyc  = 0;
  int            readyCyc  = 0;
  logic [W-1:0]  mA        = '0;
  logic [W-1:0]  mB        = '0;
  logic          mSigned   = 1'b0;
  logic [2*W-1:0] expResult = '0;

  // Observations, written by the monitor
  int stallCnt     = 0;
  int readyCnt     = 0;
  int lastReadyCyc = 0;

  task automatic check(input string name, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Arithmetic reference: {remainder, quotient}
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
    int sa;
    int sb;
    int q;
    int r;
    if (b == '0) return {a, {W{1'b1}}};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;  // SystemVerilog remainder carries the dividend's sign
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Monitor: compares every cycle against the timeline model
  initial begin
    logic expStall;
    logic expReady;
    forever begin
      @(negedge clk);
      expReady = active && (cyc == readyCyc);
      if (expReady) expResult = model(mA, mB, mSigned);
      expStall = start_i & ~annul_i & active & (cyc < readyCyc);
      check("stall_o",  {63'd0, stall_o}, {63'd0, expStall});
      check("ready_o",  {63'd0, ready_o}, {63'd0, expReady});
      check("result_o", result_o, expResult);
      if (stall_o) stallCnt++;
      if (ready_o) begin
        readyCnt++;
        lastReadyCyc = cyc;
      end
    end
  end

  // Driver tasks: each one is entered and left 1 time unit after a rising edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    a_i      = a;
    b_i      = b;
    signed_i = s;
    start_i  = 1'b1;
    mA       = a;
    mB       = b;
    mSigned  = s;
    startCyc = cyc;
    readyCyc = cyc + ((b == '0) ? 1 : LAT);
    active   = 1'b1;
    stallCnt = 0;
  endtask

  task automatic waitDone();
    do begin
      @(posedge clk);
      #1;
    end while (cyc != readyCyc + 1);
    start_i = 1'b0;
    active  = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doOp(input string name, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s,
                      input logic [2*W-1:0] hand);
    issue(a, b, s);
    waitDone();
    check(name, result_o, hand);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Global time limit
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    int r1;
    int rc;
    logic [2*W-1:0] held;

    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result_o, '0);
    check("reset_ready",  {63'd0, ready_o}, '0);
    check("reset_stall",  {63'd0, stall_o}, '0);
    rst = 1'b0;
    idle(2);

    // DIVU 100/7 with start held: 33 stall cycles, ready at T+33
    issue(32'd100, 32'd7, 1'b0);
    waitDone();
    check("divu_100_7", result_o, {32'd2, 32'd14});
    check("divu_100_7_stall_cycles", 64'(stallCnt), 64'(LAT));
    check("divu_100_7_latency", 64'(lastReadyCyc - startCyc), 64'(LAT));
    idle(1);

    doOp("div_m7_2",   32'hFFFF_FFF9, 32'd2,        1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    doOp("div_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD});
    doOp("div_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
    doOp("divu_max_1", 32'hFFFF_FFFF, 32'd1,        1'b0, {32'd0, 32'hFFFF_FFFF});
    doOp("divu_big",   32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, {32'd1, 32'd1});
    doOp("divu_hi",    32'h8000_0000, 32'hC000_0000, 1'b0, {32'h8000_0000, 32'd0});
    doOp("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14});
    doOp("divu_3_5",   32'd3,         32'd5,        1'b0, {32'd3, 32'd0});
    doOp("div_0_m3",   32'd0,         32'hFFFF_FFFD, 1'b1, {32'd0, 32'd0});
    idle(1);

    // Divide by zero: one stall cycle, ready at T+1
    issue(32'd5, 32'd0, 1'b0);
    waitDone();
    check("divu_5_0", result_o, {32'd5, 32'hFFFF_FFFF});
    check("divu_5_0_stall_cycles", 64'(stallCnt), 64'd1);
    check("divu_5_0_latency", 64'(lastReadyCyc - startCyc), 64'd1);
    doOp("div_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    idle(2);

    // Annul at T+10: stall drops at once, no ready, result_o kept
    held = result_o;
    rc   = readyCnt;
    issue(32'd100, 32'd7, 1'b0);
    waitUntil(startCyc + 10);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    active  = 1'b0;
    idle(LAT + 5);
    check("annul_result_kept", result_o, held);
    check("annul_no_ready", 64'(readyCnt), 64'(rc));
    // The unit must be back in IDLE and accept new work
    doOp("after_annul", 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30});
    idle(2);

    // Async reset at T+10: outputs zero immediately
    issue(32'd100, 32'd7, 1'b0);
    waitUntil(startCyc + 10);
    rst       = 1'b1;
    start_i   = 1'b0;
    active    = 1'b0;
    expResult = '0;
    #1;
    check("rst_mid_result", result_o, '0);
    check("rst_mid_ready",  {63'd0, ready_o}, '0);
    check("rst_mid_stall",  {63'd0, stall_o}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(LAT + 3);
    check("rst_no_late_ready", result_o, '0);
    doOp("after_rst", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    idle(2);

    // Back-to-back DIVU: start re-asserted in the cycle after DONE
    issue(32'd1234567, 32'd1000, 1'b0);
    waitDone();
    check("b2b_first", result_o, {32'd567, 32'd1234});
    r1 = lastReadyCyc;
    issue(32'hDEAD_BEEF, 32'd16, 1'b0);
    waitDone();
    check("b2b_second", result_o, {32'd15, 32'h0DEA_DBEE});
    check("b2b_spacing", 64'(lastReadyCyc - r1), 64'(LAT + 1));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
    $finish;
  end

endmodule
